// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read-port to valid/ready stream adapter with a 2-entry skid buffer.
// Optional FIFO_RD_STATS_EN adds rd_count and ovf_err outputs.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic                  ovf_err
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                  occ;
  occ_e                  occ_nxt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] slot1;
  logic                  pop;
  logic [2:0]            level;
  logic                  unused_depth;

  assign unused_depth = (DEPTH > 1);

  assign pop   = m_valid && m_ready;
  assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

  // Count the same-cycle pop so a ready sink sees one word per cycle.
  assign fifo_rd_en = drain_en && !fifo_empty && !rst
                    && (level < 3'd2);

  always_comb begin
    occ_nxt = occ;
    unique case (occ)
      EMPTY: if (inflight) occ_nxt = ONE;
      ONE: begin
        if (inflight && !pop)      occ_nxt = TWO;
        else if (!inflight && pop) occ_nxt = EMPTY;
      end
      TWO: if (pop && !inflight) occ_nxt = ONE;
      default: occ_nxt = EMPTY;
    endcase
  end

  // m_data is the head slot; slot1 holds the word queued behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= EMPTY;
      inflight <= 1'b0;
      m_data   <= '0;
      slot1    <= '0;
      m_valid  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      occ      <= occ_nxt;
      inflight <= fifo_rd_en;
      m_valid  <= (occ_nxt != EMPTY);
      busy     <= fifo_rd_en || (occ_nxt != EMPTY);
      unique case (occ)
        EMPTY: begin
          if (inflight) m_data <= fifo_dout;
        end
        ONE: begin
          if (inflight && pop) m_data <= fifo_dout;
          else if (inflight)   slot1  <= fifo_dout;
        end
        TWO: begin
          if (pop) begin
            m_data <= slot1;
            if (inflight) slot1 <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= 16'd0;
      ovf_err  <= 1'b0;
    end else begin
      if (pop) rd_count <= rd_count + 16'd1;
      if (occ == TWO && inflight && !pop) ovf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: queue-backed FIFO model plus
// a scoreboard of expected stream words.
module tb_fifo_rd_stream_adapter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       drain_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic [7:0] fifo_dout = 8'h00;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic       busy;
`ifdef FIFO_RD_STATS_EN
  logic [15:0] rd_count;
  logic        ovf_err;
`endif

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;

  logic [7:0] q[$];
  logic [7:0] wr_q[$];
  logic [7:0] sb[$];

  fifo_rd_stream_adapter #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .drain_en(drain_en),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_ready(m_ready),
    .busy(busy)
`ifdef FIFO_RD_STATS_EN
    ,
    .rd_count(rd_count),
    .ovf_err(ovf_err)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, writes land at the clock edge.
  always @(posedge clk) begin
    if (fifo_rd_en && q.size() != 0) fifo_dout <= q.pop_front();
    while (wr_q.size() != 0) q.push_back(wr_q.pop_front());
    fifo_empty <= (q.size() == 0);
  end

  // Stream monitor and scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en) begin
        checks++;
        if (fifo_empty !== 1'b0) begin
          failures++;
          $display("FAIL rd_while_empty: rd_en=1 empty=%b", fifo_empty);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        acc_cnt++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL stream_extra: got %h expected none", m_data);
        end else begin
          logic [7:0] exp_d;
          exp_d = sb.pop_front();
          if (m_data !== exp_d) begin
            failures++;
            $display("FAIL stream_data: got %h expected %h", m_data, exp_d);
          end
        end
      end
    end
  end

  task automatic fifo_write(input logic [7:0] d);
    wr_q.push_back(d);
    sb.push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drain_en = 1'b1;
    m_ready = 1'b0;
    fifo_write(8'hA5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b expected 0", m_valid);
    end
    checks++;
    if (m_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got %h expected 00", m_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en);
    end
    step();
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (6) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL reset_drain: left %0d expected 0", sb.size());
    end
    drain_en = 1'b0;
  endtask

  task automatic test_stream();
    int first_rd;
    int first_v;
    int last_v;
    int nv;
    first_rd = -1;
    first_v = -1;
    last_v = -1;
    nv = 0;
    m_ready = 1'b1;
    fifo_write(8'h11);
    fifo_write(8'h22);
    fifo_write(8'h33);
    drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en && first_rd < 0) first_rd = i;
      if (m_valid) begin
        nv++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    checks++;
    if (first_rd < 0 || first_v - first_rd != 2) begin
      failures++;
      $display("FAIL t1_latency: got %0d expected 2", first_v - first_rd);
    end
    checks++;
    if (nv != 3 || last_v - first_v != 2) begin
      failures++;
      $display("FAIL t1_b2b: got %0d words span %0d expected 3/2",
               nv, last_v - first_v);
    end
    step();
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL t1_idle: busy=%b valid=%b expected 0/0", busy, m_valid);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL t1_left: got %0d expected 0", sb.size());
    end
    drain_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int nrd;
    int first_a;
    int last_a;
    int na;
    logic bad;
    nrd = 0;
    first_a = -1;
    last_a = -1;
    na = 0;
    bad = 1'b0;
    m_ready = 1'b0;
    drain_en = 1'b1;
    for (int i = 0; i < 8; i++) fifo_write(8'h80 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fifo_rd_en) nrd++;
      if (m_valid && m_data !== 8'h80) bad = 1'b1;
    end
    checks++;
    if (nrd != 2) begin
      failures++;
      $display("FAIL t2_reads: got %0d expected 2", nrd);
    end
    checks++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL t2_hold: rd=%b valid=%b busy=%b expected 0/1/1",
               fifo_rd_en, m_valid, busy);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL t2_stable: got %h expected 80", m_data);
    end
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        na++;
        if (first_a < 0) first_a = i;
        last_a = i;
      end
    end
    checks++;
    if (na != 8 || last_a - first_a != 7) begin
      failures++;
      $display("FAIL t2_b2b: got %0d span %0d expected 8/7",
               na, last_a - first_a);
    end
    step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL t2_left: got %0d expected 0", sb.size());
    end
    drain_en = 1'b0;
  endtask

  task automatic test_toggle();
    int a0;
    a0 = acc_cnt;
    drain_en = 1'b1;
    for (int i = 0; i < 8; i++) fifo_write(8'h40 + 8'(i));
    for (int i = 0; i < 40; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    checks++;
    if (sb.size() != 0 || acc_cnt - a0 != 8) begin
      failures++;
      $display("FAIL t3_count: got %0d left %0d expected 8/0",
               acc_cnt - a0, sb.size());
    end
    m_ready = 1'b1;
    drain_en = 1'b0;
  endtask

  task automatic test_drain_pause();
    int a0;
    int nrd;
    nrd = 0;
    m_ready = 1'b1;
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) fifo_write(8'hC0 + 8'(i));
    step();
    step();
    drain_en = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL t4_issue: got %b expected 1", fifo_rd_en);
    end
    step();
    drain_en = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fifo_rd_en) nrd++;
    end
    step();
    checks++;
    if (nrd != 0) begin
      failures++;
      $display("FAIL t4_no_rd: got %0d expected 0", nrd);
    end
    checks++;
    if (acc_cnt - a0 != 1 || sb.size() != 3) begin
      failures++;
      $display("FAIL t4_inflight: got %0d left %0d expected 1/3",
               acc_cnt - a0, sb.size());
    end
    drain_en = 1'b1;
    repeat (10) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL t4_resume: left %0d expected 0", sb.size());
    end
    drain_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    m_ready = 1'b0;
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) fifo_write(8'hE0 + 8'(i));
    repeat (3) step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hE0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL t5_pre: valid=%b data=%h busy=%b expected 1/e0/1",
               m_valid, m_data, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    foreach (q[i]) sb.push_back(q[i]);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL t5_post: valid=%b data=%h busy=%b expected 0/00/0",
               m_valid, m_data, busy);
    end
    step();
    m_ready = 1'b1;
    repeat (10) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL t5_rest: left %0d expected 0", sb.size());
    end
    drain_en = 1'b0;
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    checks++;
    if (ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL t6_ovf: got %b expected 0", ovf_err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (rd_count !== 16'd0) begin
      failures++;
      $display("FAIL t6_clr0: got %h expected 0000", rd_count);
    end
    m_ready = 1'b1;
    drain_en = 1'b1;
    for (int i = 0; i < 20; i++) fifo_write(8'(i));
    repeat (40) step();
    checks++;
    if (rd_count !== 16'h0014 || ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL t6_count: got %h ovf=%b expected 0014/0",
               rd_count, ovf_err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (rd_count !== 16'd0) begin
      failures++;
      $display("FAIL t6_clr: got %h expected 0000", rd_count);
    end
    drain_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_drain_pause();
    test_mid_reset();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
